// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
// Optional feature macro (used by fetch_queue): FETCH_QUEUE_STALL_CNT_EN.
package fetch_pkg;

   localparam int WORD_W     = 16;
   localparam int ADDR_W     = 16;
   localparam int LONG_BIT   = 15;
   localparam int WORD_BYTES = WORD_W / 8;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   // Opcode words with LONG_BIT set are followed by an immediate word.
   function automatic logic is_long(input word_t w);
      return w[LONG_BIT];
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {addr, word} entries for the fetch queue.
// One push per cycle; pop removes 0, 1 or 2 entries; flush empties it.
module fetch_fifo #(
   parameter  int DEPTH = 4,
   parameter  int DW    = 16,
   parameter  int AW    = 16,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [AW-1:0]    push_addr,
   input  logic [DW-1:0]    push_word,
   input  logic [1:0]       pop_n,
   output logic [AW-1:0]    head_addr,
   output logic [DW-1:0]    head_word,
   output logic [DW-1:0]    next_word,
   output logic [CNT_W-1:0] count
);

   logic [AW-1:0]    addr_mem [DEPTH];
   logic [DW-1:0]    word_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_1;

   // Entry storage; contents are only ever read below the occupancy count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= push_addr;
         word_mem[wr_ptr] <= push_word;
      end
   end

   // Pointer and occupancy tracking; DEPTH is a power of 2 so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         rd_ptr <= rd_ptr + PTR_W'(pop_n);
         count  <= count + CNT_W'(push) - CNT_W'(pop_n);
      end
   end

   assign rd_ptr_1  = rd_ptr + PTR_W'(1);
   assign head_addr = addr_mem[rd_ptr];
   assign head_word = word_mem[rd_ptr];
   assign next_word = word_mem[rd_ptr_1];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential prefetch into a small queue,
// one (possibly two-word) instruction per cycle to decode, redirect flush.
// Optional: FETCH_QUEUE_STALL_CNT_EN adds a saturating decode-stall counter.
module fetch_queue #(
   parameter int              WORD_W   = fetch_pkg::WORD_W,
   parameter int              ADDR_W   = fetch_pkg::ADDR_W,
   parameter int              DEPTH    = 4,
   parameter int              LONG_BIT = fetch_pkg::LONG_BIT,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_data,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              hold,
   input  logic              consume,
   output logic              ir_valid,
   output logic [WORD_W-1:0] ir_out,
   output logic [WORD_W-1:0] k16_out,
   output logic [ADDR_W-1:0] pc_out
`ifdef FETCH_QUEUE_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(WORD_W / 8);

   logic [ADDR_W-1:0] fetch_pc;
   logic              push;
   logic              pop;
   logic [1:0]        pop_n;
   logic              have_head;
   logic              have_two;
   logic              long_op;
   logic [ADDR_W-1:0] head_addr;
   logic [WORD_W-1:0] head_word;
   logic [WORD_W-1:0] next_word;
   logic [CNT_W-1:0]  count;

   assign mem_req  = !rst && (count < DEPTH_C);
   assign mem_addr = fetch_pc;
   // A word acked in the redirect cycle belongs to the old stream and is dropped.
   assign push     = mem_req && mem_ack && !redirect;

   // Fetch pc: reset, then redirect target (halfword aligned), else advance on each accepted word.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
      end else if (redirect) begin
         fetch_pc <= redirect_pc & ~ADDR_W'(1);
      end else if (push) begin
         fetch_pc <= fetch_pc + STEP;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .DW    (WORD_W),
      .AW    (ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (push),
      .push_addr (fetch_pc),
      .push_word (mem_data),
      .pop_n     (pop_n),
      .head_addr (head_addr),
      .head_word (head_word),
      .next_word (next_word),
      .count     (count)
   );

   // Decode-side presentation; an empty queue shows zeros and the fetch pc.
   assign have_head = (count != '0);
   assign have_two  = (count >= CNT_W'(2));
   assign ir_out    = have_head ? head_word : '0;
   assign long_op   = ir_out[LONG_BIT];
   assign ir_valid  = have_head && (!long_op || have_two);
   assign k16_out   = (long_op && have_two) ? next_word : '0;
   assign pc_out    = have_head ? head_addr : fetch_pc;

   assign pop   = ir_valid && consume && !hold && !redirect;
   assign pop_n = !pop ? 2'd0 : (long_op ? 2'd2 : 2'd1);

`ifdef FETCH_QUEUE_STALL_CNT_EN
   // Count cycles where decode is willing but has no complete instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (!ir_valid && !hold && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus queues expected instructions,
// a negedge monitor compares every instruction the DUT hands to decode.
module tb_fetch_queue;

   typedef struct {
      logic [15:0] ir;
      logic [15:0] k16;
      logic [15:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_data;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        hold;
   logic        consume;
   logic        ir_valid;
   logic [15:0] ir_out;
   logic [15:0] k16_out;
   logic [15:0] pc_out;
`ifdef FETCH_QUEUE_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   logic [15:0] imem [256];
   exp_t        sb [$];
   int          n_chk  = 0;
   int          n_fail = 0;
   int          pops   = 0;

   always #5 clk = ~clk;

   assign mem_data = imem[mem_addr[8:1]];

   fetch_queue dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_data    (mem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .hold        (hold),
      .consume     (consume),
      .ir_valid    (ir_valid),
      .ir_out      (ir_out),
      .k16_out     (k16_out),
      .pc_out      (pc_out)
`ifdef FETCH_QUEUE_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   task automatic expect_instr(input logic [15:0] ir, input logic [15:0] k16, input logic [15:0] pc);
      exp_t e;
      e.ir  = ir;
      e.k16 = k16;
      e.pc  = pc;
      sb.push_back(e);
   endtask

   // Called just after a rising edge; consumes n instructions, bounded.
   task automatic take(input int n, input int exp_cycles);
      int tgt;
      int t;
      tgt     = pops + n;
      t       = 0;
      consume = 1'b1;
      while (pops < tgt && t < 40) begin
         @(posedge clk);
         #1;
         t++;
      end
      consume = 1'b0;
      n_chk++;
      if (pops < tgt) begin
         n_fail++;
         $display("FAIL take_timeout: got %0d pops expected %0d", n - (tgt - pops), n);
      end else if (exp_cycles >= 0 && t != exp_cycles) begin
         n_fail++;
         $display("FAIL take_cycles: got %0d cycles expected %0d", t, exp_cycles);
      end
   endtask

   // Monitor: every pop the DUT performs must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && ir_valid && consume && !hold && !redirect) begin
         pops++;
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pop: got ir=0x%04h pc=0x%04h expected no instruction", ir_out, pc_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (ir_out !== e.ir || k16_out !== e.k16 || pc_out !== e.pc) begin
               n_fail++;
               $display("FAIL pop_%0d: got ir=0x%04h k16=0x%04h pc=0x%04h expected ir=0x%04h k16=0x%04h pc=0x%04h",
                        pops, ir_out, k16_out, pc_out, e.ir, e.k16, e.pc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 16'(i + 1);
      imem[128] = 16'h8010;
      imem[129] = 16'h1234;
      imem[130] = 16'h0003;
      imem[131] = 16'h0004;
      imem[255] = 16'h0042;

      rst = 1'b1; mem_ack = 1'b0; redirect = 1'b0; redirect_pc = '0;
      hold = 1'b0; consume = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_req",  16'(mem_req),  16'h0);
      chk("rst_ir_valid", 16'(ir_valid), 16'h0);
      chk("rst_ir_out",   ir_out,        16'h0000);
      chk("rst_k16_out",  k16_out,       16'h0000);
      chk("rst_pc_out",   pc_out,        16'h0000);

`ifdef FETCH_QUEUE_STALL_CNT_EN
      @(posedge clk); #1;
      rst = 1'b0; mem_ack = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("stall_after_5", stall_cnt, 16'd5);
      redirect = 1'b1; redirect_pc = 16'h0000;
      @(posedge clk); #1;
      redirect = 1'b0;
      @(negedge clk);
      chk("stall_redirect", stall_cnt, 16'd6);
`endif

      // Streaming short opcodes from RESET_PC, one per cycle after fill
      @(posedge clk); #1;
      rst = 1'b0; mem_ack = 1'b1;
      for (int i = 0; i < 6; i++) expect_instr(16'(i + 1), 16'h0000, 16'(2 * i));
      take(6, 7);

      // Let the queue fill, then hold with consume high
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("full_mem_req", 16'(mem_req), 16'h0);
      @(posedge clk); #1;
      hold = 1'b1; consume = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("hold_mem_req",  16'(mem_req),  16'h0);
      chk("hold_ir_valid", 16'(ir_valid), 16'h1);
      chk("hold_ir_out",   ir_out,        16'h0007);
      chk("hold_pc_out",   pc_out,        16'h000C);
      chk("hold_k16_out",  k16_out,       16'h0000);
      @(posedge clk); #1;
      hold = 1'b0;
      expect_instr(16'h0007, 16'h0000, 16'h000C);
      expect_instr(16'h0008, 16'h0000, 16'h000E);
      expect_instr(16'h0009, 16'h0000, 16'h0010);
      take(3, 3);

      // Redirect to an odd pc while full, ack high in the redirect cycle
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("refill_mem_req", 16'(mem_req), 16'h0);
      @(posedge clk); #1;
      redirect = 1'b1; redirect_pc = 16'h0101;
      @(posedge clk); #1;
      redirect = 1'b0;
      @(negedge clk);
      chk("redir_mem_addr", mem_addr,      16'h0100);
      chk("redir_mem_req",  16'(mem_req),  16'h1);
      chk("redir_ir_valid", 16'(ir_valid), 16'h0);
      chk("redir_pc_out",   pc_out,        16'h0100);
      @(posedge clk); #1;
      @(negedge clk);
      chk("long_cnt1_valid", 16'(ir_valid), 16'h0);
      chk("long_cnt1_ir",    ir_out,        16'h8010);
      chk("long_cnt1_k16",   k16_out,       16'h0000);
      @(posedge clk); #1;
      expect_instr(16'h8010, 16'h1234, 16'h0100);
      expect_instr(16'h0003, 16'h0000, 16'h0104);
      take(2, -1);

      // Address wrap and dropping of a word acked during redirect
      mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 16'hFFFE;
      @(posedge clk); #1;
      redirect = 1'b0;
      @(negedge clk);
      chk("wrap_mem_addr0", mem_addr,      16'hFFFE);
      chk("wrap_ir_valid0", 16'(ir_valid), 16'h0);
      @(posedge clk); #1;
      redirect = 1'b1; redirect_pc = 16'hFFFE; mem_ack = 1'b1;
      @(posedge clk); #1;
      redirect = 1'b0;
      @(negedge clk);
      chk("drop_mem_addr", mem_addr,      16'hFFFE);
      chk("drop_ir_valid", 16'(ir_valid), 16'h0);
      chk("drop_pc_out",   pc_out,        16'hFFFE);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      chk("wrap_mem_addr", mem_addr,      16'h0000);
      chk("wrap_ir_valid", 16'(ir_valid), 16'h1);
      chk("wrap_pc_out",   pc_out,        16'hFFFE);
      @(posedge clk); #1;
      mem_ack = 1'b1;
      expect_instr(16'h0042, 16'h0000, 16'hFFFE);
      expect_instr(16'h0001, 16'h0000, 16'h0000);
      expect_instr(16'h0002, 16'h0000, 16'h0002);
      take(3, -1);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("sb_empty", 16'(sb.size()), 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
